// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment driver: scans NUM_DIGITS hex digits, loads new values at frame
// boundaries, and supports decimal points, leading-zero blanking and configurable pin polarity.
module seven_seg_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0]         PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF     = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

  // Glyphs are stored in active-low form; polarity is applied at the output stage.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h58;
      4'h8: g = 7'h00;
      4'h9: g = 7'h18;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [VW-1:0]         pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  strobe;
  logic                  wrap;

  always_comb begin
    strobe       = (presc_q == PRESC_LAST);
    wrap         = strobe && (idx_q == IDX_LAST);
    presc_d      = strobe ? '0 : presc_q + PW'(1);
    idx_d        = idx_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;

    if (strobe) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    // A load coinciding with the wrap bypasses pending so it shows in the very next frame.
    if (wrap) begin
      if (load) begin
        disp_val_d = value;
        disp_dp_d  = dp_in;
      end else if (pend_valid_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
  end

  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] blank_vec;
  logic [NUM_DIGITS-1:0] onehot;
  logic                  dp_active;

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    zero_run  = 1'b1;
    blank_vec = '0;
    onehot    = '0;
    dp_active = 1'b0;
    seg_d     = SEG_OFF;

    // A digit is blank only if it and every more significant digit are zero.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (disp_val_q[4*i +: 4] == 4'h0);
      blank_vec[i] = zero_run && (i != 0);
    end

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx_q) begin
        cur_nib   = disp_val_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
        cur_blank = blank_lz && blank_vec[i];
        onehot[i] = enable;
      end
    end

    if (enable && !cur_blank) begin
      seg_d = SEG_ACTIVE_LOW ? glyph(cur_nib) : ~glyph(cur_nib);
    end
    dp_active = enable && !cur_blank && cur_dp;
    dp_d      = SEG_ACTIVE_LOW ? ~dp_active : dp_active;
    an_d      = AN_ACTIVE_LOW ? ~onehot : onehot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = wrap;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: a 4-digit active-low instance and a 2-digit active-high instance
// share stimulus and are compared each cycle against a cycle-count based reference model.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic        enable;
  logic        blank_lz;
  logic [15:0] value;
  logic [3:0]  dp_in;

  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;
  logic [3:0]  an0;
  logic [1:0]  an1;
  logic        ft0, ft1;

  logic [7:0]  value1;
  logic [1:0]  dp_in1;
  assign value1 = value[7:0];
  assign dp_in1 = dp_in[1:0];

  seven_seg_scanner #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .enable(enable), .seg(seg0), .dp(dp0), .an(an0),
    .frame_tick(ft0)
  );

  seven_seg_scanner #(
    .NUM_DIGITS(2), .REFRESH_DIV(3), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .value(value1), .dp_in(dp_in1), .load(load),
    .blank_lz(blank_lz), .enable(enable), .seg(seg1), .dp(dp1), .an(an1),
    .frame_tick(ft1)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          n;
  int          nd_cfg [2];
  int          rd_cfg [2];
  bit          sal_cfg [2];
  bit          aal_cfg [2];
  logic [6:0]  glyph_tab [16];
  logic [31:0] disp_v [2];
  logic [31:0] pend_v [2];
  logic [7:0]  disp_d [2];
  logic [7:0]  pend_d [2];
  bit          pend_ok [2];

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int k = 0; k < 2; k++) begin
      disp_v[k]  = '0;
      pend_v[k]  = '0;
      disp_d[k]  = '0;
      pend_d[k]  = '0;
      pend_ok[k] = 1'b0;
    end
  endtask

  // Expected pin values for instance k while digit idx of the model display is selected.
  task automatic model_out(input int k, input int idx, input logic en, input logic blz,
                           output logic [6:0] s, output logic d, output logic [7:0] a);
    logic [31:0] upper;
    logic [7:0]  onehot;
    logic [7:0]  mask;
    bit          blank;
    upper  = disp_v[k] >> (4 * idx);
    blank  = blz && (idx != 0) && (upper == 32'd0);
    mask   = 8'((1 << nd_cfg[k]) - 1);
    onehot = en ? 8'(1 << idx) : 8'h00;
    a      = aal_cfg[k] ? (~onehot & mask) : onehot;
    s      = (en && !blank) ? glyph_tab[upper[3:0]] : 7'h7F;
    if (!sal_cfg[k]) s = ~s;
    d = en && !blank && disp_d[k][idx];
    if (sal_cfg[k]) d = ~d;
  endtask

  function automatic logic [6:0] seg_of(input int k);
    return (k == 0) ? seg0 : seg1;
  endfunction

  function automatic logic [7:0] an_of(input int k);
    return (k == 0) ? 8'(an0) : 8'(an1);
  endfunction

  // Called just after a falling edge: drives inputs, predicts, crosses one rising edge, checks.
  task automatic applyStimulus(input logic ld, input logic [15:0] v, input logic [3:0] d,
                               input logic en, input logic blz);
    logic [6:0]  es [2];
    logic        ed [2];
    logic [7:0]  ea [2];
    logic [31:0] lv;
    logic [7:0]  ldp;
    int          fr;
    int          idx;
    load     = ld;
    value    = v;
    dp_in    = d;
    enable   = en;
    blank_lz = blz;
    for (int k = 0; k < 2; k++) begin
      fr  = nd_cfg[k] * rd_cfg[k];
      checkOutput($sformatf("frame_tick%0d", k), 8'((k == 0) ? ft0 : ft1),
                  8'((n % fr) == fr - 1));
      idx = (n / rd_cfg[k]) % nd_cfg[k];
      model_out(k, idx, en, blz, es[k], ed[k], ea[k]);
      lv  = 32'(v) & ((32'd1 << (4 * nd_cfg[k])) - 32'd1);
      ldp = 8'(d) & 8'((1 << nd_cfg[k]) - 1);
      if ((n % fr) == fr - 1) begin
        if (ld) begin
          disp_v[k] = lv;
          disp_d[k] = ldp;
        end else if (pend_ok[k]) begin
          disp_v[k] = pend_v[k];
          disp_d[k] = pend_d[k];
        end
        pend_ok[k] = 1'b0;
      end else if (ld) begin
        pend_v[k]  = lv;
        pend_d[k]  = ldp;
        pend_ok[k] = 1'b1;
      end
    end
    n++;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("seg%0d", k), 8'(seg_of(k)), 8'(es[k]));
      checkOutput($sformatf("dp%0d", k), 8'((k == 0) ? dp0 : dp1), 8'(ed[k]));
      checkOutput($sformatf("an%0d", k), an_of(k), ea[k]);
    end
  endtask

  task automatic idle(input int cnt, input logic en, input logic blz);
    repeat (cnt) applyStimulus(1'b0, 16'h0000, 4'h0, en, blz);
  endtask

  // While reset is held every pin must sit at its inactive level.
  task automatic checkReset(input string tag);
    logic [6:0] s;
    logic       d;
    logic [7:0] a;
    for (int k = 0; k < 2; k++) begin
      model_out(k, 0, 1'b0, 1'b0, s, d, a);
      checkOutput($sformatf("%s_seg%0d", tag, k), 8'(seg_of(k)), 8'(s));
      checkOutput($sformatf("%s_dp%0d", tag, k), 8'((k == 0) ? dp0 : dp1), 8'(d));
      checkOutput($sformatf("%s_an%0d", tag, k), an_of(k), a);
      checkOutput($sformatf("%s_ft%0d", tag, k), 8'((k == 0) ? ft0 : ft1), 8'h00);
    end
  endtask

  initial begin
    nd_cfg[0] = 4;  rd_cfg[0] = 4;  sal_cfg[0] = 1'b1;  aal_cfg[0] = 1'b1;
    nd_cfg[1] = 2;  rd_cfg[1] = 3;  sal_cfg[1] = 1'b0;  aal_cfg[1] = 1'b0;
    glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
                  7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = '0;
    dp_in    = '0;
    enable   = 1'b1;
    blank_lz = 1'b0;
    model_reset();

    @(negedge clk);
    checkReset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] scanning zeros");
    idle(20, 1'b1, 1'b0);

    $display("[TB] mid-frame load 12AF");
    applyStimulus(1'b1, 16'h12AF, 4'b0100, 1'b1, 1'b0);
    idle(40, 1'b1, 1'b0);

    $display("[TB] two loads in one frame");
    while (n % 16 != 2) idle(1, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h1111, 4'b0001, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h00C3, 4'b0000, 1'b1, 1'b0);
    idle(30, 1'b1, 1'b0);

    $display("[TB] load on frame wrap");
    while (n % 16 != 15) idle(1, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h4D2E, 4'b1001, 1'b1, 1'b0);
    idle(20, 1'b1, 1'b0);

    $display("[TB] leading-zero suppression");
    applyStimulus(1'b1, 16'h0005, 4'b1110, 1'b1, 1'b1);
    idle(36, 1'b1, 1'b1);
    applyStimulus(1'b1, 16'h0000, 4'b0000, 1'b1, 1'b1);
    idle(36, 1'b1, 1'b1);
    idle(4, 1'b1, 1'b0);

    $display("[TB] polarity and enable");
    applyStimulus(1'b1, 16'h0080, 4'b0010, 1'b1, 1'b0);
    idle(20, 1'b1, 1'b0);
    idle(20, 1'b0, 1'b0);
    idle(8, 1'b1, 1'b0);

    $display("[TB] async reset with load pending");
    while (n % 16 != 5) idle(1, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'hBEEF, 4'b1111, 1'b1, 1'b0);
    idle(2, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(40, 1'b1, 1'b0);

    $display("[TB] randomized traffic");
    repeat (600) begin
      applyStimulus(($urandom % 6) == 0, 16'($urandom), 4'($urandom),
                    ($urandom % 8) != 0, ($urandom % 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
